// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool stage.
//   DATA_W : sample width (matches the convolution engine output)
//   IMG_W  : OFM row/column length; the pooled map is (IMG_W-1)x(IMG_W-1)
//   CNT_W  : width of the row/column counters
//   state_t: pooling sequencer states
//   IDX_*  : window position encoding used by the optional argmax output
package pool_pkg;

  localparam int DATA_W = 36;
  localparam int IMG_W  = 5;
  localparam int CNT_W  = $clog2(IMG_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    POOL = 2'd2
  } state_t;

  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

endpackage

// File: rtl/max4_cmp.sv
// Combinational 4-input unsigned maximum, built as a two-level compare tree.
//   in_tl, in_tr, in_bl, in_br : window elements
//   max_val                    : largest element, passed through unchanged
//   max_idx                    : winning position (only when MAXPOOL_ARGMAX_EN is defined)
// Every compare is strict, so equal values resolve to the lower index.
module max4_cmp
  import pool_pkg::*;
(
  input  logic [DATA_W-1:0] in_tl,
  input  logic [DATA_W-1:0] in_tr,
  input  logic [DATA_W-1:0] in_bl,
  input  logic [DATA_W-1:0] in_br,
`ifdef MAXPOOL_ARGMAX_EN
  output logic [1:0]        max_idx,
`endif
  output logic [DATA_W-1:0] max_val
);

  logic              top_sel;
  logic              bot_sel;
  logic              fin_sel;
  logic [DATA_W-1:0] top_max;
  logic [DATA_W-1:0] bot_max;

  assign top_sel = in_tr > in_tl;
  assign bot_sel = in_br > in_bl;
  assign top_max = top_sel ? in_tr : in_tl;
  assign bot_max = bot_sel ? in_br : in_bl;
  assign fin_sel = bot_max > top_max;
  assign max_val = fin_sel ? bot_max : top_max;

`ifdef MAXPOOL_ARGMAX_EN
  // Encoding TL=0, TR=1, BL=2, BR=3 maps directly onto {bottom-row, right-column}.
  assign max_idx = fin_sel ? {1'b1, bot_sel} : {1'b0, top_sel};
`endif

endmodule

// File: rtl/ofm_maxpool2x2.sv
// Streaming 2x2 (stride 1) max-pool of the raster-order OFM stream, using a
// one-row line buffer instead of frame storage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : In_OFM holds a sample this cycle (bubbles allowed)
//   In_OFM      : unsigned OFM sample
//   out_valid   : Out_Pool valid this cycle
//   Out_Pool    : registered window maximum
//   frame_done  : pulse with the last pooled output of a frame
//   out_idx     : winning window position, present only with MAXPOOL_ARGMAX_EN
//
// state | meaning
// IDLE  | waiting for the first sample of a frame (accepted as (0,0))
// FILL  | row 0, loading the line buffer, no output
// POOL  | rows 1..IMG_W-1, a window completes on every column >= 1
module ofm_maxpool2x2
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_OFM,
  output logic              out_valid,
  output logic [DATA_W-1:0] Out_Pool,
`ifdef MAXPOOL_ARGMAX_EN
  output logic [1:0]        out_idx,
`endif
  output logic              frame_done
);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  col_q;
  logic [CNT_W-1:0]  row_q;
  logic [DATA_W-1:0] lb [IMG_W];
  logic [DATA_W-1:0] tl_q;
  logic [DATA_W-1:0] bl_q;
  logic [DATA_W-1:0] lb_top;
  logic [DATA_W-1:0] max_val;
  logic              col_last;
  logic              row_last;
  logic              frame_end;
  logic              win_ok;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]        max_idx;
`endif

  assign col_last  = col_q == CNT_W'(IMG_W - 1);
  assign row_last  = row_q == CNT_W'(IMG_W - 1);
  assign frame_end = in_valid && row_last && col_last;
  assign lb_top    = lb[col_q];
  // POOL only covers rows >= 1, so a non-zero column is enough to close a window.
  assign win_ok    = in_valid && (state_q == POOL) && (col_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = FILL;
      FILL:    if (in_valid && col_last) state_d = POOL;
      POOL:    if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + CNT_W'(1);
      end else begin
        col_q <= col_q + CNT_W'(1);
      end
    end
  end

  // lb[c] is read (as TR) and overwritten with the new row in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) lb[i] <= '0;
      tl_q <= '0;
      bl_q <= '0;
    end else if (in_valid) begin
      lb[col_q] <= In_OFM;
      tl_q      <= lb_top;
      bl_q      <= In_OFM;
    end
  end

  max4_cmp u_max4_cmp (
    .in_tl   (tl_q),
    .in_tr   (lb_top),
    .in_bl   (bl_q),
    .in_br   (In_OFM),
`ifdef MAXPOOL_ARGMAX_EN
    .max_idx (max_idx),
`endif
    .max_val (max_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      Out_Pool   <= '0;
`ifdef MAXPOOL_ARGMAX_EN
      out_idx    <= IDX_TL;
`endif
    end else begin
      out_valid  <= win_ok;
      frame_done <= win_ok && frame_end;
      if (win_ok) begin
        Out_Pool <= max_val;
`ifdef MAXPOOL_ARGMAX_EN
        out_idx  <= max_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ofm_maxpool2x2.sv
// Randomised and directed bench for ofm_maxpool2x2 against a frame-array
// reference model. Builds with or without MAXPOOL_ARGMAX_EN.
module tb_ofm_maxpool2x2;
  import pool_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] In_OFM = '0;
  logic              out_valid;
  logic [DATA_W-1:0] Out_Pool;
  logic              frame_done;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]        out_idx;
`endif

  always #5 clk = ~clk;

  ofm_maxpool2x2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .In_OFM     (In_OFM),
    .out_valid  (out_valid),
    .Out_Pool   (Out_Pool),
`ifdef MAXPOOL_ARGMAX_EN
    .out_idx    (out_idx),
`endif
    .frame_done (frame_done)
  );

  typedef struct {
    logic [DATA_W-1:0] val;
    int                idx;
    bit                last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e_cur;
  logic [DATA_W-1:0] frm [IMG_W][IMG_W];
  int                pos = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  int                fd_cnt = 0;
  int                fd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: place the sample in a frame array; each sample with r>=1, c>=1
  // closes window (r,c) whose max and first-max position are queued.
  task automatic model_accept(input logic [DATA_W-1:0] v);
    int r, c, best;
    logic [DATA_W-1:0] w [4];
    r = pos / IMG_W;
    c = pos % IMG_W;
    frm[r][c] = v;
    if (r >= 1 && c >= 1) begin
      w[0] = frm[r-1][c-1];
      w[1] = frm[r-1][c];
      w[2] = frm[r][c-1];
      w[3] = v;
      best = 0;
      for (int k = 1; k < 4; k++) if (w[k] > w[best]) best = k;
      exp_q.push_back('{val: w[best], idx: best, last: (r == IMG_W-1 && c == IMG_W-1)});
    end
    pos = (pos + 1) % (IMG_W * IMG_W);
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    In_OFM   = v;
    model_accept(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      In_OFM   = DATA_W'($urandom());
    end
  endtask

  task automatic drain(input string tag);
    idle(3);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < IMG_W*IMG_W; i++) send(DATA_W'(i));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", out_valid, 0);
        end else begin
          e_cur = exp_q.pop_front();
          chk("pool_val", Out_Pool, e_cur.val);
`ifdef MAXPOOL_ARGMAX_EN
          chk("pool_idx", out_idx, e_cur.idx);
`endif
          chk("frame_done", frame_done, e_cur.last);
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d outputs still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pool", Out_Pool, 0);
    chk("rst_frame_done", frame_done, 0);
`ifdef MAXPOOL_ARGMAX_EN
    chk("rst_out_idx", out_idx, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: contiguous ramp
    ramp_frame();
    drain("drain_ramp");

    // 2: descending ramp, TL wins every window
    for (int i = IMG_W*IMG_W-1; i >= 0; i--) send(DATA_W'(i));
    drain("drain_desc");

    // 3: bubbles after every third sample plus across the row-1 wrap
    for (int i = 0; i < IMG_W*IMG_W; i++) begin
      send(DATA_W'(i));
      if (i % 3 == 2) idle(1);
      if (i == 2*IMG_W-1) idle(2);
    end
    drain("drain_bubble");

    // 4: two frames back-to-back
    fd0 = fd_cnt;
    ramp_frame();
    ramp_frame();
    drain("drain_b2b");
    chk("b2b_fd_pulses", fd_cnt - fd0, 2);

    // 5: reset after the 12th sample, inputs still toggling during reset
    for (int i = 0; i < 12; i++) send(DATA_W'(i + 100));
    drain("drain_prereset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      In_OFM   = DATA_W'($urandom());
      @(negedge clk);
      chk("inrst_out_valid", out_valid, 0);
      chk("inrst_out_pool", Out_Pool, 0);
      chk("inrst_frame_done", frame_done, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    pos      = 0;
    ramp_frame();
    drain("drain_postreset");

    // 6: all equal, then a single large spike at (2,2)
    for (int i = 0; i < IMG_W*IMG_W; i++) send(DATA_W'(7));
    drain("drain_equal");
    for (int i = 0; i < IMG_W*IMG_W; i++) send((i == 2*IMG_W+2) ? 36'hF_FFFF_FFFF : DATA_W'(7));
    drain("drain_spike");

    // Random frames: wide values, small values for ties, random bubbles
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < IMG_W*IMG_W; i++) begin
        if (f % 2 == 0) send(DATA_W'({$urandom(), $urandom()}));
        else            send(DATA_W'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    drain("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
